// File: rtl/ram_bank_ctrl.sv
// Banked on-chip RAM with a shared bus port and a clear sequencer that fills
// every bank with CLEAR_VAL, one address per cycle across all banks in parallel.
module ram_bank_ctrl #(
    parameter int                NUM_BANKS = 2,
    parameter int                ADDR_W    = 11,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] CLEAR_VAL = 8'h00,
    parameter logic [DATA_W-1:0] OPEN_BUS  = 8'h46
) (
    input  logic                 memclk,
    input  logic                 reset,
    input  logic                 clear_req,
    input  logic [NUM_BANKS-1:0] bank_sel,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic                 we,
    output logic [DATA_W-1:0]    rdata,
    output logic                 clearing,
    output logic                 clear_done,
    output logic                 sel_err
);

    localparam int                DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_DONE} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      cnt_q, cnt_d;
    logic                   clr_req_q, clr_req_d;
    logic                   armed_q, armed_d;
    logic [NUM_BANKS-1:0]   sel_q, sel_d;
    logic                   acc_clr_q, acc_clr_d;
    logic                   clearing_q, clearing_d;
    logic                   done_q, done_d;
    logic                   sel_err_q, sel_err_d;

    logic                   clr_rise;
    logic                   in_clear;
    logic                   sel_multi;
    logic [ADDR_W-1:0]      ram_addr;
    logic [DATA_W-1:0]      ram_wdata;
    logic [NUM_BANKS-1:0]   ram_we;
    logic [DATA_W-1:0]      bank_rd [NUM_BANKS];

    // armed_q blocks a clear_req held high through reset from counting as an edge
    always_comb begin
        clr_rise   = clear_req & ~clr_req_q & armed_q;
        in_clear   = (state_q == ST_CLEAR);
        sel_multi  = ($countones(bank_sel) > 1);
        state_d    = state_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_rise) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = ADDR_W'(cnt_q + 1'b1);
                end
            end
            default: begin
                if (clr_rise) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
        endcase
        clr_req_d  = clear_req;
        armed_d    = armed_q | ~clear_req;
        sel_d      = bank_sel;
        acc_clr_d  = in_clear;
        clearing_d = (state_d == ST_CLEAR);
        done_d     = (state_d == ST_DONE);
        sel_err_d  = sel_multi;
    end

    always_ff @(posedge memclk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            clr_req_q  <= 1'b0;
            armed_q    <= 1'b0;
            sel_q      <= '0;
            acc_clr_q  <= 1'b0;
            clearing_q <= 1'b0;
            done_q     <= 1'b0;
            sel_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_req_q  <= clr_req_d;
            armed_q    <= armed_d;
            sel_q      <= sel_d;
            acc_clr_q  <= acc_clr_d;
            clearing_q <= clearing_d;
            done_q     <= done_d;
            sel_err_q  <= sel_err_d;
        end
    end

    // One shared port per bank: the sequencer owns it for the whole clear
    assign ram_addr  = in_clear ? cnt_q : addr;
    assign ram_wdata = in_clear ? CLEAR_VAL : wdata;

    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            logic [DATA_W-1:0] mem [DEPTH];
            logic [DATA_W-1:0] rd_q;

            assign ram_we[gi] = in_clear | (we & bank_sel[gi] & ~sel_multi);

            // No reset here so that reset never disturbs stored contents
            always_ff @(posedge memclk) begin
                if (ram_we[gi]) begin
                    mem[ram_addr] <= ram_wdata;
                    rd_q          <= ram_wdata;
                end else begin
                    rd_q <= mem[ram_addr];
                end
            end

            assign bank_rd[gi] = rd_q;
        end
    endgenerate

    always_comb begin
        rdata = OPEN_BUS;
        if (!acc_clr_q && !in_clear && ($countones(sel_q) == 1)) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                if (sel_q[i]) rdata = bank_rd[i];
            end
        end
    end

    assign clearing   = clearing_q;
    assign clear_done = done_q;
    assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_ram_bank_ctrl.sv
// Directed bench for ram_bank_ctrl at default parameters: bus access, select
// errors, full clear, clear aborted by reset and clear restart.
module tb_ram_bank_ctrl;

    logic        memclk = 1'b0;
    logic        reset;
    logic        clear_req;
    logic [1:0]  bank_sel;
    logic [10:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic [7:0]  rdata;
    logic        clearing;
    logic        clear_done;
    logic        sel_err;

    int n_cmp = 0;
    int n_bad = 0;

    ram_bank_ctrl dut (
        .memclk     (memclk),
        .reset      (reset),
        .clear_req  (clear_req),
        .bank_sel   (bank_sel),
        .addr       (addr),
        .wdata      (wdata),
        .we         (we),
        .rdata      (rdata),
        .clearing   (clearing),
        .clear_done (clear_done),
        .sel_err    (sel_err)
    );

    always #5 memclk = ~memclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge memclk);
        #1;
    endtask

    task automatic bus_idle();
        bank_sel = 2'b00;
        we       = 1'b0;
        addr     = '0;
        wdata    = '0;
    endtask

    task automatic wr(input logic [1:0] s, input logic [10:0] a, input logic [7:0] d);
        bank_sel = s;
        addr     = a;
        wdata    = d;
        we       = 1'b1;
        tick();
        bus_idle();
    endtask

    task automatic rd(input string tag, input logic [1:0] s, input logic [10:0] a, input logic [7:0] exp);
        bank_sel = s;
        addr     = a;
        we       = 1'b0;
        tick();
        bus_idle();
        chk(tag, rdata, exp);
    endtask

    int n;

    initial begin
        reset     = 1'b1;
        clear_req = 1'b1;
        bus_idle();
        #2;
        chk("rst_rdata", rdata, 8'h46);
        chk("rst_clearing", clearing, 1'b0);
        chk("rst_done", clear_done, 1'b0);
        chk("rst_sel_err", sel_err, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        tick(); tick(); tick();
        chk("held_req_no_clear", clearing, 1'b0);
        clear_req = 1'b0;
        tick();

        // basic bus access
        wr(2'b10, 11'h123, 8'hA5);
        wr(2'b01, 11'h123, 8'h3C);
        rd("b1_123", 2'b10, 11'h123, 8'hA5);
        rd("b0_123", 2'b01, 11'h123, 8'h3C);
        rd("nosel", 2'b00, 11'h123, 8'h46);

        // write-first
        bank_sel = 2'b01; addr = 11'h055; wdata = 8'h77; we = 1'b1;
        tick();
        bus_idle();
        chk("wr_first", rdata, 8'h77);

        // multi-hot select
        bank_sel = 2'b11; addr = 11'h123; wdata = 8'hFF; we = 1'b1;
        tick();
        bus_idle();
        chk("multi_sel_err", sel_err, 1'b1);
        chk("multi_rdata", rdata, 8'h46);
        tick();
        chk("multi_err_drop", sel_err, 1'b0);
        rd("multi_b0", 2'b01, 11'h123, 8'h3C);
        rd("multi_b1", 2'b10, 11'h123, 8'hA5);

        // clear aborted by reset at counter 0x300
        wr(2'b01, 11'h2FF, 8'h11);
        wr(2'b01, 11'h300, 8'h22);
        wr(2'b10, 11'h300, 8'h33);
        wr(2'b10, 11'h7FF, 8'h44);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("clr1_start", clearing, 1'b1);
        for (int k = 0; k < 'h300; k++) tick();
        chk("clr1_mid", clearing, 1'b1);
        reset = 1'b1;
        #1;
        chk("rst_mid_clearing", clearing, 1'b0);
        chk("rst_mid_rdata", rdata, 8'h46);
        tick();
        reset = 1'b0;
        tick();
        rd("ab_b0_000", 2'b01, 11'h000, 8'h00);
        rd("ab_b0_2FF", 2'b01, 11'h2FF, 8'h00);
        rd("ab_b1_123", 2'b10, 11'h123, 8'h00);
        rd("ab_b0_300", 2'b01, 11'h300, 8'h22);
        rd("ab_b1_300", 2'b10, 11'h300, 8'h33);
        rd("ab_b1_7FF", 2'b10, 11'h7FF, 8'h44);

        // full clear with a dropped bus write
        wr(2'b01, 11'h400, 8'h99);
        wr(2'b01, 11'h000, 8'hC3);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        bank_sel = 2'b01; addr = 11'h000; wdata = 8'h5A; we = 1'b1;
        tick();
        bus_idle();
        chk("clr_wr_rdata", rdata, 8'h46);
        n = 1;
        while (clearing && n < 5000) begin
            tick();
            n++;
        end
        chk("clr_len", n, 2048);
        chk("clr_done", clear_done, 1'b1);
        rd("c_b0_000", 2'b01, 11'h000, 8'h00);
        rd("c_b0_400", 2'b01, 11'h400, 8'h00);
        rd("c_b0_7FF", 2'b01, 11'h7FF, 8'h00);
        rd("c_b1_000", 2'b10, 11'h000, 8'h00);
        rd("c_b1_400", 2'b10, 11'h400, 8'h00);
        rd("c_b1_7FF", 2'b10, 11'h7FF, 8'h00);
        chk("done_holds", clear_done, 1'b1);

        // restart: second rising edge lands as the counter reaches 0x100
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("rs_done_low", clear_done, 1'b0);
        for (int k = 1; k < 'h100; k++) tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        n = 'h100;
        while (clearing && n < 6000) begin
            tick();
            n++;
        end
        chk("restart_len", n, 'h100 + 2048);
        chk("restart_done", clear_done, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
